tetris_game_driver: RTL and testbench

Initiator-side game sequencer for the Tetris engine. It buffers a 16-piece game loaded by the host, issues one piece per round on the engine's `in_valid`/`tetrominoes`/`position` interface, waits for each `score_valid` response, and ends the game on `fail`, on `tetris_valid`, or on a response timeout. It sits between the host/testbench loader and the engine, and returns a single result record per game.

---
 rtl/tetris_pkg.sv | 41 ++++
 rtl/tetris_game_driver_fifo.sv | 51 +++++
 rtl/tetris_game_driver.sv | 179 +++++++++++++++++
 tb/tb_tetris_game_driver.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece codes, board geometry, driver states and
// a helper that flattens per-row board data into the engine's board vector.
package tetris_pkg;

  typedef enum logic [2:0] {
    PC_O   = 3'd0,
    PC_I   = 3'd1,
    PC_I_H = 3'd2,
    PC_J   = 3'd3,
    PC_L_R = 3'd4,
    PC_L   = 3'd5,
    PC_S   = 3'd6,
    PC_Z   = 3'd7
  } piece_e;

  localparam int BOARD_W    = 6;
  localparam int BOARD_H    = 12;
  localparam int ROUNDS     = 16;
  localparam int BOARD_BITS = BOARD_W * BOARD_H;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } drv_state_e;

  // Row r lands at bits [r*BOARD_W +: BOARD_W], so row 11 ends up in the MSBs.
  function automatic logic [BOARD_BITS-1:0] pack_rows(
    input logic [BOARD_H-1:0][BOARD_W-1:0] rows
  );
    logic [BOARD_BITS-1:0] b;
    b = '0;
    for (int r = 0; r < BOARD_H; r++) begin
      b[r*BOARD_W +: BOARD_W] = rows[r];
    end
    return b;
  endfunction

endpackage

// File: rtl/tetris_game_driver_fifo.sv
// 16-entry piece buffer ({piece,pos} per entry) with independent write/read
// pointers; the read port is an address so the driver can look one entry ahead.
module tetris_piece_fifo
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [5:0] wr_data,
  input  logic       rd_clr,
  input  logic       rd_inc,
  input  logic [3:0] rd_addr,
  output logic [5:0] rd_data,
  output logic [4:0] count,
  output logic [3:0] rd_ptr
);

  logic [5:0] mem [ROUNDS];
  logic [3:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (clr) begin
        wr_ptr <= '0;
        count  <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 4'd1;
        count  <= count + 5'd1;
      end
      if (rd_clr) begin
        rd_ptr <= '0;
      end else if (rd_inc) begin
        rd_ptr <= rd_ptr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tetris_game_driver.sv
// Game sequencer: buffers 16 host-loaded pieces, feeds them to the engine one
// round at a time and reports a single result record per game.
module tetris_game_driver
  import tetris_pkg::*;
#(
  parameter int GAP     = 0,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [2:0]            load_piece,
  input  logic [2:0]            load_pos,
  output logic                  load_ready,
  input  logic                  start,
  output logic                  busy,
  output logic                  in_valid,
  output logic [2:0]            tetrominoes,
  output logic [2:0]            position,
  input  logic                  score_valid,
  input  logic                  fail,
  input  logic                  tetris_valid,
  input  logic [3:0]            score,
  input  logic [BOARD_BITS-1:0] tetris,
  output logic                  done,
  output logic                  res_fail,
  output logic [3:0]            res_score,
  output logic [4:0]            res_rounds,
  output logic [BOARD_BITS-1:0] res_board,
  output logic                  err_timeout,
  output logic                  err_protocol
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  drv_state_e       state;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic [4:0]       count;
  logic [3:0]       rd_ptr;
  logic [3:0]       rd_addr;
  logic [5:0]       rd_data;
  logic             wr_en;
  logic             start_ok;
  logic             last_round;
  logic             rd_inc;

  assign wr_en      = load_valid && load_ready;
  assign start_ok   = (state == ST_IDLE) && start && (count == 5'(ROUNDS));
  assign last_round = (rd_ptr == 4'(ROUNDS - 1));
  assign rd_inc     = (state == ST_WAIT) && score_valid && !fail && !tetris_valid && !last_round;

  // Entry to present on the edge that enters ISSUE: slot 0 on start, the next
  // slot when leaving WAIT directly, the current slot when leaving GAP.
  always_comb begin
    rd_addr = rd_ptr;
    if (state == ST_IDLE) begin
      rd_addr = '0;
    end else if (state == ST_WAIT) begin
      rd_addr = rd_ptr + 4'd1;
    end
  end

  tetris_piece_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_DONE),
    .wr_en   (wr_en),
    .wr_data ({load_piece, load_pos}),
    .rd_clr  (start_ok),
    .rd_inc  (rd_inc),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      timer        <= '0;
      gap_cnt      <= '0;
      load_ready   <= 1'b0;
      busy         <= 1'b0;
      in_valid     <= 1'b0;
      tetrominoes  <= '0;
      position     <= '0;
      done         <= 1'b0;
      res_fail     <= 1'b0;
      res_score    <= '0;
      res_rounds   <= '0;
      res_board    <= '0;
      err_timeout  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      done        <= 1'b0;
      in_valid    <= 1'b0;
      tetrominoes <= '0;
      position    <= '0;
      if (score_valid && (state != ST_WAIT)) begin
        err_protocol <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          load_ready <= (count + 5'(wr_en)) < 5'(ROUNDS);
          if (start_ok) begin
            state                     <= ST_ISSUE;
            busy                      <= 1'b1;
            load_ready                <= 1'b0;
            in_valid                  <= 1'b1;
            {tetrominoes, position}   <= rd_data;
            res_fail                  <= 1'b0;
            res_score                 <= '0;
            res_rounds                <= '0;
            res_board                 <= '0;
            err_timeout               <= 1'b0;
            err_protocol              <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
          timer <= '0;
        end
        ST_WAIT: begin
          if (score_valid) begin
            res_score <= score;
            if (fail || tetris_valid) begin
              res_fail   <= fail;
              res_board  <= tetris;
              res_rounds <= 5'(rd_ptr) + 5'd1;
              if (tetris_valid && !fail && !last_round) begin
                err_protocol <= 1'b1;
              end
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (last_round) begin
              // Engine kept playing past the final piece without declaring the end.
              err_protocol <= 1'b1;
              res_rounds   <= 5'(ROUNDS);
              state        <= ST_DONE;
              done         <= 1'b1;
            end else if (GAP == 0) begin
              state                   <= ST_ISSUE;
              in_valid                <= 1'b1;
              {tetrominoes, position} <= rd_data;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else if (timer == TMR_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            res_rounds  <= 5'(rd_ptr);
            state       <= ST_DONE;
            done        <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP - 1)) begin
            state                   <= ST_ISSUE;
            in_valid                <= 1'b1;
            {tetrominoes, position} <= rd_data;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_game_driver.sv
// Directed bench for tetris_game_driver with a 3-cycle-latency engine model.
module tb_tetris_game_driver;

  localparam logic [71:0] PAT = 72'h9A56781234F0F00F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [2:0]  load_piece = '0;
  logic [2:0]  load_pos = '0;
  logic        start = 1'b0;
  logic        start_g = 1'b0;
  logic        score_valid = 1'b0;
  logic        fail = 1'b0;
  logic        tetris_valid = 1'b0;
  logic [3:0]  score = '0;
  logic [71:0] tetris = '0;

  logic        load_ready, busy, in_valid, done, res_fail, err_timeout, err_protocol;
  logic [2:0]  tetrominoes, position;
  logic [3:0]  res_score;
  logic [4:0]  res_rounds;
  logic [71:0] res_board;

  logic        load_ready_g, busy_g, in_valid_g, done_g, res_fail_g, err_timeout_g, err_protocol_g;
  logic [2:0]  tetrominoes_g, position_g;
  logic [3:0]  res_score_g;
  logic [4:0]  res_rounds_g;
  logic [71:0] res_board_g;

  tetris_game_driver #(.GAP(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_piece(load_piece), .load_pos(load_pos),
    .load_ready(load_ready), .start(start), .busy(busy), .in_valid(in_valid),
    .tetrominoes(tetrominoes), .position(position), .score_valid(score_valid), .fail(fail),
    .tetris_valid(tetris_valid), .score(score), .tetris(tetris), .done(done), .res_fail(res_fail),
    .res_score(res_score), .res_rounds(res_rounds), .res_board(res_board),
    .err_timeout(err_timeout), .err_protocol(err_protocol)
  );

  tetris_game_driver #(.GAP(2), .TIMEOUT(15)) dut_g (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_piece(load_piece), .load_pos(load_pos),
    .load_ready(load_ready_g), .start(start_g), .busy(busy_g), .in_valid(in_valid_g),
    .tetrominoes(tetrominoes_g), .position(position_g), .score_valid(score_valid), .fail(fail),
    .tetris_valid(tetris_valid), .score(score), .tetris(tetris), .done(done_g), .res_fail(res_fail_g),
    .res_score(res_score_g), .res_rounds(res_rounds_g), .res_board(res_board_g),
    .err_timeout(err_timeout_g), .err_protocol(err_protocol_g)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  int   fail_round = 0;
  int   silent_from = 1000;
  int   spur_at = -1;
  logic eng_sel = 1'b0;

  int         t0 = 0;
  int         round = 0;
  int         n_iv = 0;
  int         done_cyc = -1;
  int         et_cyc = -1;
  logic       done_seen = 1'b0;
  int         iv_log [32];
  logic [2:0] iv_pc [32];
  logic [2:0] iv_pos [32];
  logic [3:0] pipe = '0;

  // Monitor + engine model: cycle numbers are relative to the start cycle.
  always @(negedge clk) begin
    logic iv, dn, st, et;
    iv = eng_sel ? in_valid_g : in_valid;
    dn = eng_sel ? done_g : done;
    st = eng_sel ? start_g : start;
    et = eng_sel ? err_timeout_g : err_timeout;
    if (st) begin
      t0 = cyc; round = 0; n_iv = 0; done_seen = 1'b0; done_cyc = -1; et_cyc = -1;
    end
    if (iv && n_iv < 32) begin
      iv_log[n_iv] = cyc - t0;
      iv_pc[n_iv]  = eng_sel ? tetrominoes_g : tetrominoes;
      iv_pos[n_iv] = eng_sel ? position_g : position;
      n_iv++;
    end
    if (dn && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc - t0;
    end
    if (et && et_cyc < 0) et_cyc = cyc - t0;
    score_valid  = 1'b0;
    fail         = 1'b0;
    tetris_valid = 1'b0;
    if (rst) pipe = '0;
    else     pipe = {pipe[2:0], iv};
    if (pipe[3]) begin
      round++;
      if (round < silent_from) begin
        score_valid = 1'b1;
        score       = 4'(round + 2);
        if (round == fail_round) begin
          fail = 1'b1; tetris_valid = 1'b1; tetris = PAT;
        end else if (round == 16) begin
          tetris_valid = 1'b1; tetris = ~PAT;
        end
      end
    end
    if (spur_at >= 0 && (cyc - t0) == spur_at) score_valid = 1'b1;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_n(input int n, input logic [2:0] pc, input logic step);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 64) begin
      if (eng_sel ? load_ready_g : load_ready) begin
        load_valid = 1'b1;
        load_piece = step ? 3'(int'(pc) + acc) : pc;
        load_pos   = step ? 3'(acc % 6) : 3'd0;
        acc++;
      end else begin
        load_valid = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    load_valid = 1'b0;
    n_vec++;
    if (acc != n) begin n_err++; $display("FAIL load_count: got %0d accepted, want %0d", acc, n); end
  endtask

  task automatic pulse_start(input logic g);
    if (g) start_g = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_g = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_seen && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (!done_seen) begin n_err++; $display("FAIL done_wait: no done within %0d cycles, want done", budget); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, in_valid, done, load_ready, err_timeout, err_protocol, res_fail} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags: got %b, want 0", {busy, in_valid, done, load_ready, err_timeout, err_protocol, res_fail});
    end
    n_vec++;
    if ({res_rounds, res_score, tetrominoes, position} !== 15'd0 || res_board !== 72'd0) begin
      n_err++; $display("FAIL reset_data: got rounds %0d score %0d board %h, want 0", res_rounds, res_score, res_board);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, want 1", load_ready); end
  endtask

  task automatic test_full_game();
    int bad = 0;
    load_n(16, 3'd2, 1'b0);
    pulse_start(1'b0);
    wait_done(200);
    n_vec++;
    if (n_iv !== 16) begin n_err++; $display("FAIL full_iv_count: got %0d, want 16", n_iv); end
    n_vec++;
    if (iv_log[0] !== 1 || iv_log[15] !== 61) begin
      n_err++; $display("FAIL full_iv_times: got first %0d last %0d, want 1 61", iv_log[0], iv_log[15]);
    end
    for (int i = 1; i < 16; i++) if (iv_log[i] - iv_log[i-1] != 4) bad++;
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL full_spacing: got %0d bad gaps, want 0", bad); end
    n_vec++;
    if (done_cyc !== 65) begin n_err++; $display("FAIL full_done_cyc: got %0d, want 65", done_cyc); end
    n_vec++;
    if (res_rounds !== 5'd16 || res_fail !== 1'b0 || res_score !== 4'd2) begin
      n_err++; $display("FAIL full_result: got rounds %0d fail %b score %0d, want 16 0 2", res_rounds, res_fail, res_score);
    end
    n_vec++;
    if ({err_timeout, err_protocol} !== 2'b00) begin
      n_err++; $display("FAIL full_errs: got %b, want 00", {err_timeout, err_protocol});
    end
    n_vec++;
    if (res_board !== ~PAT) begin n_err++; $display("FAIL full_board: got %h, want %h", res_board, ~PAT); end
    n_vec++;
    if (iv_pc[7] !== 3'd2 || iv_pos[7] !== 3'd0) begin
      n_err++; $display("FAIL full_piece: got %0d/%0d, want 2/0", iv_pc[7], iv_pos[7]);
    end
    n_vec++;
    if (busy !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL full_idle: got busy %b ready %b, want 0 1", busy, load_ready);
    end
  endtask

  task automatic test_fail_round();
    fail_round = 5;
    load_n(16, 3'd0, 1'b1);
    pulse_start(1'b0);
    wait_done(200);
    fail_round = 0;
    n_vec++;
    if (res_rounds !== 5'd5 || res_fail !== 1'b1 || res_score !== 4'd7) begin
      n_err++; $display("FAIL fail_result: got rounds %0d fail %b score %0d, want 5 1 7", res_rounds, res_fail, res_score);
    end
    n_vec++;
    if (res_board !== PAT) begin n_err++; $display("FAIL fail_board: got %h, want %h", res_board, PAT); end
    n_vec++;
    if (done_cyc !== 21) begin n_err++; $display("FAIL fail_done_cyc: got %0d, want 21", done_cyc); end
    n_vec++;
    if (iv_pc[4] !== 3'd4 || iv_pos[4] !== 3'd4 || iv_pc[1] !== 3'd1) begin
      n_err++; $display("FAIL fail_pieces: got %0d/%0d and %0d, want 4/4 and 1", iv_pc[4], iv_pos[4], iv_pc[1]);
    end
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (n_iv !== 5) begin n_err++; $display("FAIL fail_no_sixth: got %0d issues, want 5", n_iv); end
    n_vec++;
    if (load_ready !== 1'b1 || err_protocol !== 1'b0) begin
      n_err++; $display("FAIL fail_after: got ready %b perr %b, want 1 0", load_ready, err_protocol);
    end
  endtask

  task automatic test_timeout();
    silent_from = 4;
    load_n(16, 3'd5, 1'b0);
    pulse_start(1'b0);
    wait_done(200);
    silent_from = 1000;
    n_vec++;
    if (et_cyc !== 30 || done_cyc !== 30) begin
      n_err++; $display("FAIL tmo_cycles: got err %0d done %0d, want 30 30", et_cyc, done_cyc);
    end
    n_vec++;
    if (err_timeout !== 1'b1 || res_rounds !== 5'd3 || res_score !== 4'd5) begin
      n_err++; $display("FAIL tmo_result: got tmo %b rounds %0d score %0d, want 1 3 5", err_timeout, res_rounds, res_score);
    end
    n_vec++;
    if (n_iv !== 4 || res_fail !== 1'b0) begin
      n_err++; $display("FAIL tmo_issues: got %0d fail %b, want 4 0", n_iv, res_fail);
    end
  endtask

  task automatic test_short_load();
    load_n(10, 3'd1, 1'b0);
    pulse_start(1'b0);
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (n_iv !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL short_ignored: got issues %0d busy %b, want 0 0", n_iv, busy);
    end
    n_vec++;
    if (err_timeout !== 1'b1) begin n_err++; $display("FAIL short_hold: got %b, want 1", err_timeout); end
    load_n(6, 3'd3, 1'b0);
    n_vec++;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b, want 0", load_ready); end
    load_valid = 1'b1; load_piece = 3'd7; load_pos = 3'd5;
    @(posedge clk); #1;
    load_valid = 1'b0;
    n_vec++;
    if (load_ready !== 1'b0) begin n_err++; $display("FAIL load17_ready: got %b, want 0", load_ready); end
    pulse_start(1'b0);
    wait_done(200);
    n_vec++;
    if (n_iv !== 16 || res_rounds !== 5'd16 || err_timeout !== 1'b0) begin
      n_err++; $display("FAIL short_game: got issues %0d rounds %0d tmo %b, want 16 16 0", n_iv, res_rounds, err_timeout);
    end
    n_vec++;
    if (iv_pc[0] !== 3'd1 || iv_pc[9] !== 3'd1 || iv_pc[10] !== 3'd3 || iv_pc[15] !== 3'd3) begin
      n_err++; $display("FAIL short_order: got %0d %0d %0d %0d, want 1 1 3 3", iv_pc[0], iv_pc[9], iv_pc[10], iv_pc[15]);
    end
  endtask

  task automatic test_gap();
    do_reset();
    eng_sel = 1'b1;
    spur_at = 5;
    load_n(16, 3'd6, 1'b0);
    pulse_start(1'b1);
    wait_done(300);
    spur_at = -1;
    n_vec++;
    if (iv_log[0] !== 1 || iv_log[1] !== 7 || iv_log[15] !== 91) begin
      n_err++; $display("FAIL gap_times: got %0d %0d %0d, want 1 7 91", iv_log[0], iv_log[1], iv_log[15]);
    end
    n_vec++;
    if (done_cyc !== 95 || n_iv !== 16) begin
      n_err++; $display("FAIL gap_done: got cyc %0d issues %0d, want 95 16", done_cyc, n_iv);
    end
    n_vec++;
    if (err_protocol_g !== 1'b1 || res_rounds_g !== 5'd16) begin
      n_err++; $display("FAIL gap_perr: got perr %b rounds %0d, want 1 16", err_protocol_g, res_rounds_g);
    end
    load_n(16, 3'd6, 1'b0);
    pulse_start(1'b1);
    n_vec++;
    if (err_protocol_g !== 1'b0 || busy_g !== 1'b1) begin
      n_err++; $display("FAIL gap_restart: got perr %b busy %b, want 0 1", err_protocol_g, busy_g);
    end
    wait_done(300);
    eng_sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_n(16, 3'd4, 1'b0);
    pulse_start(1'b0);
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b, want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, in_valid, done, load_ready, res_rounds, res_score} !== 13'd0) begin
      n_err++; $display("FAIL mid_async: got %b, want 0", {busy, in_valid, done, load_ready, res_rounds, res_score});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (done_seen !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %b, want 0", done_seen); end
    pulse_start(1'b0);
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (n_iv !== 0 || busy !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_count: got issues %0d busy %b ready %b, want 0 0 1", n_iv, busy, load_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_game();
    test_fail_round();
    test_timeout();
    test_short_load();
    test_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
